fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 2, giving the decode-side instruction buffer entries (power of two, >=2).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 fetchPc  output  32  current PC, driven to the predictor lookup.
REQ-006 fetchHit  input  1  predictor says predicted-taken for fetchPc (same cycle).
REQ-007 fetchTarget  input  32  predicted target for fetchPc.
REQ-008 imemReq  output  1  instruction memory request valid.
REQ-009 imemAddr  output  32  request address; always equals fetchPc.
REQ-010 imemReady  input  1  memory accepts request this cycle.
REQ-011 imemRspValid  input  1  response valid, at least 1 cycle after accept.
REQ-012 imemRspData  input  32  instruction word.
REQ-013 exRedirect  input  1  EX mispredict/redirect strobe.
REQ-014 exRedirectPc  input  32  corrected PC.
REQ-015 decValid  output  1  buffer head valid to decode.
REQ-016 decReady  input  1  decode consumes head.
REQ-017 decInstr, decPc, decPredTarget  output  32 each  head instruction, its PC, its predicted next PC.
REQ-018 decPredTaken  output  1  head was predicted taken.

Function
REQ-019 The block SHALL implement a two-state FSM: REQ (may issue) and WAIT (one request outstanding); at most one request outstanding.
REQ-020 imemReq SHALL be 1 only when state==REQ, exRedirect==0 and (fifoCount + 0) < FIFO_DEPTH.
REQ-021 On accept (imemReq && imemReady): pc <= fetchHit ? fetchTarget : pc+4; latch pending PC, fetchHit, predicted next PC; state -> WAIT.
REQ-022 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000); bits [1:0] of every pc load SHALL be forced to 0.
REQ-023 In WAIT, imemRspValid SHALL push {imemRspData, pending PC, pending prediction} into the FIFO unless the pending request is stale; state -> REQ either way.
REQ-024 imemRspValid while in REQ with no outstanding request SHALL be ignored.
REQ-025 FIFO SHALL be first-in first-out; pop on decValid && decReady; simultaneous push and pop SHALL leave count unchanged; push is never attempted when full (guaranteed by REQ-020).
REQ-026 decValid SHALL equal (fifoCount != 0); dec* outputs SHALL show the head entry combinationally from storage.
REQ-027 exRedirect SHALL have priority over all other events: pc <= exRedirectPc, FIFO emptied (any same-cycle pop or push discarded), no request issued that cycle.
REQ-028 If exRedirect occurs while in WAIT and imemRspValid is 0, a stale flag SHALL be set; the later response SHALL be dropped and clear the flag.
REQ-029 If exRedirect and imemRspValid coincide in WAIT, the response SHALL be dropped, stale stays 0, state -> REQ.
REQ-030 Fetch-to-decode latency with imemReady=1 and 1-cycle memory SHALL be 2 cycles (issue at cycle N, decValid at N+2).

Reset
REQ-031 While rst==0: pc=RESET_PC, state=REQ, stale=0, fifoCount=0, FIFO pointers 0; hence decValid=0, fetchPc=imemAddr=RESET_PC.
REQ-032 imemReq SHALL be 0 during reset and SHALL first assert in the first cycle after rst deasserts.
REQ-033 Reset asserted mid-request SHALL discard the outstanding request; a response arriving after reset release in REQ is ignored per REQ-024.

Verification
REQ-034 Straight-line: reset release, imemReady=1, 1-cycle rsp, fetchHit=0, decReady=1 -> decPc sequence 0x0,0x4,0x8 with decPredTaken=0.
REQ-035 Prediction: fetchHit=1, fetchTarget=0x100 at PC 0x8 -> next imemAddr=0x100; entry for 0x8 has decPredTaken=1, decPredTarget=0x100.
REQ-036 Backpressure: decReady=0 -> after 2 entries imemReq stays 0, decPc holds 0x0; release decReady -> fetch resumes at 0x8 with no lost or duplicated PC.
REQ-037 Stale: redirect to 0x200 while WAIT, response 3 cycles later -> response dropped, decValid=0 until instruction from 0x200 arrives.
REQ-038 Coincident: exRedirect with imemRspValid and decReady in same cycle, FIFO holding 1 -> FIFO empty, next imemAddr=0x200 (redirect to 0x203 also gives 0x200).
REQ-039 Wrap: exRedirectPc=0xFFFF_FFFC -> next fetch addresses 0xFFFF_FFFC then 0x0000_0000.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC register with predictor redirect, a single
// outstanding imem request, and a small buffer feeding decode.
module fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] fetchPc,
   input  logic        fetchHit,
   input  logic [31:0] fetchTarget,
   output logic        imemReq,
   output logic [31:0] imemAddr,
   input  logic        imemReady,
   input  logic        imemRspValid,
   input  logic [31:0] imemRspData,
   input  logic        exRedirect,
   input  logic [31:0] exRedirectPc,
   output logic        decValid,
   input  logic        decReady,
   output logic [31:0] decInstr,
   output logic [31:0] decPc,
   output logic [31:0] decPredTarget,
   output logic        decPredTaken,
   output logic        dbg_state
);
   // Handshakes: a transfer occurs on a rising edge where valid (imemReq or
   // decValid) and ready are both 1; valid never depends on ready.
   // imemRspValid is a one-cycle strobe with no back-pressure.
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

   typedef enum logic {S_REQ = 1'b0, S_WAIT = 1'b1} state_e;

   state_e           state_q, state_d;
   logic [31:0]      pc_q, pc_d;
   logic             stale_q, stale_d;
   logic [31:0]      pend_pc_q, pend_pc_d;
   logic             pend_taken_q, pend_taken_d;
   logic [31:0]      pend_tgt_q, pend_tgt_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic [31:0] fifo_instr_q [FIFO_DEPTH];
   logic [31:0] fifo_pc_q    [FIFO_DEPTH];
   logic [31:0] fifo_tgt_q   [FIFO_DEPTH];
   logic        fifo_taken_q [FIFO_DEPTH];

   logic        accept, push, pop;
   logic [31:0] pc_plus4, pred_next;

   always_comb begin
      pc_plus4  = pc_q + 32'd4;
      pred_next = fetchHit ? {fetchTarget[31:2], 2'b00} : pc_plus4;
      imemReq   = rst && (state_q == S_REQ) && !exRedirect && (count_q < DEPTH_C);
      accept    = imemReq && imemReady;
      pop       = (count_q != '0) && decReady && !exRedirect;
      push      = (state_q == S_WAIT) && imemRspValid && !stale_q && !exRedirect;

      state_d      = state_q;
      pc_d         = pc_q;
      stale_d      = stale_q;
      pend_pc_d    = pend_pc_q;
      pend_taken_d = pend_taken_q;
      pend_tgt_d   = pend_tgt_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;

      if (exRedirect) begin
         // A redirect flushes the buffer; an in-flight response still has to
         // be absorbed, so it is marked stale unless it lands this very cycle.
         pc_d     = {exRedirectPc[31:2], 2'b00};
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         if (state_q == S_WAIT) begin
            if (imemRspValid) begin
               state_d = S_REQ;
               stale_d = 1'b0;
            end else begin
               stale_d = 1'b1;
            end
         end
      end else begin
         case (state_q)
            S_REQ: begin
               if (accept) begin
                  pc_d         = pred_next;
                  pend_pc_d    = pc_q;
                  pend_taken_d = fetchHit;
                  pend_tgt_d   = pred_next;
                  state_d      = S_WAIT;
               end
            end
            S_WAIT: begin
               if (imemRspValid) begin
                  state_d = S_REQ;
                  stale_d = 1'b0;
               end
            end
            default: state_d = S_REQ;
         endcase
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_REQ;
         pc_q         <= RESET_PC;
         stale_q      <= 1'b0;
         pend_pc_q    <= '0;
         pend_taken_q <= 1'b0;
         pend_tgt_q   <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         stale_q      <= stale_d;
         pend_pc_q    <= pend_pc_d;
         pend_taken_q <= pend_taken_d;
         pend_tgt_q   <= pend_tgt_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
      end
   end

   // Buffer storage needs no reset: entries are only visible while count_q != 0.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_instr_q[wr_ptr_q] <= imemRspData;
         fifo_pc_q[wr_ptr_q]    <= pend_pc_q;
         fifo_tgt_q[wr_ptr_q]   <= pend_tgt_q;
         fifo_taken_q[wr_ptr_q] <= pend_taken_q;
      end
   end

   assign fetchPc       = pc_q;
   assign imemAddr      = pc_q;
   assign decValid      = (count_q != '0);
   assign decInstr      = fifo_instr_q[rd_ptr_q];
   assign decPc         = fifo_pc_q[rd_ptr_q];
   assign decPredTarget = fifo_tgt_q[rd_ptr_q];
   assign decPredTaken  = fifo_taken_q[rd_ptr_q];
   assign dbg_state     = (state_q == S_WAIT);

   logic unused_ok;
   assign unused_ok = ^{fetchTarget[1:0], exRedirectPc[1:0]};

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: table of fetch/prediction vectors, directed corner
// sequences and a random phase, all checked against a decode scoreboard.
module tb_fetch_unit;
   localparam logic [31:0] RESET_PC   = 32'h0000_0000;
   localparam int          FIFO_DEPTH = 2;
   localparam int          W          = 97;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] fetchPc;
   logic        fetchHit;
   logic [31:0] fetchTarget;
   logic        imemReq;
   logic [31:0] imemAddr;
   logic        imemReady;
   logic        imemRspValid;
   logic [31:0] imemRspData;
   logic        exRedirect;
   logic [31:0] exRedirectPc;
   logic        decValid;
   logic        decReady;
   logic [31:0] decInstr;
   logic [31:0] decPc;
   logic [31:0] decPredTarget;
   logic        decPredTaken;
   logic        dbg_state;

   always #5 clk = ~clk;

   fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk(clk), .rst(rst), .fetchPc(fetchPc), .fetchHit(fetchHit),
      .fetchTarget(fetchTarget), .imemReq(imemReq), .imemAddr(imemAddr),
      .imemReady(imemReady), .imemRspValid(imemRspValid), .imemRspData(imemRspData),
      .exRedirect(exRedirect), .exRedirectPc(exRedirectPc), .decValid(decValid),
      .decReady(decReady), .decInstr(decInstr), .decPc(decPc),
      .decPredTarget(decPredTarget), .decPredTaken(decPredTaken), .dbg_state(dbg_state)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Scoreboard entry: {instr, pc, pred_taken, pred_target}
   logic [W-1:0] exp_q[$];
   logic [31:0]  model_pc;
   bit           rsp_pending, rsp_stale, stray_rsp;
   int           rsp_delay, mem_lat;
   logic [31:0]  rsp_addr, rsp_tgt;
   logic         rsp_taken;
   int           cyc, first_dec_cyc, last_acc_cyc, t0;
   bit           last_accept, found;
   logic [31:0]  last_addr;

   typedef struct {
      logic        hit;
      logic [31:0] target;
      logic [31:0] exp_addr;
   } vec_t;
   vec_t vecs [7];

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return a ^ 32'h5A5A_0F0F;
   endfunction

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: timed out waiting for DUT", name);
   endtask

   // One clock cycle; entered and left at posedge+1 with user inputs already set.
   task automatic cycle();
      logic [W-1:0] e;
      logic         acc, pop;
      if (stray_rsp) begin
         imemRspValid = 1'b1;
         imemRspData  = 32'hDEAD_BEEF;
      end else if (rsp_pending && rsp_delay == 0) begin
         imemRspValid = 1'b1;
         imemRspData  = instr_of(rsp_addr);
      end else begin
         imemRspValid = 1'b0;
         imemRspData  = '0;
      end
      @(negedge clk);
      chk1("dec_valid", decValid, exp_q.size() != 0);
      chk1("imem_req", imemReq, !rsp_pending && !exRedirect && (exp_q.size() < FIFO_DEPTH));
      chk32("fetch_pc", fetchPc, model_pc);
      chk32("imem_addr", imemAddr, model_pc);
      chk1("dbg_state", dbg_state, rsp_pending);
      if (decValid && first_dec_cyc < 0) first_dec_cyc = cyc;
      acc         = imemReq && imemReady;
      pop         = decValid && decReady && !exRedirect;
      last_accept = acc;
      last_addr   = imemAddr;
      if (acc) last_acc_cyc = cyc;
      if (pop) begin
         if (exp_q.size() == 0) begin
            timeout("dec_pop_unexpected");
         end else begin
            e = exp_q.pop_front();
            chk32("dec_instr", decInstr, e[96:65]);
            chk32("dec_pc", decPc, e[64:33]);
            chk1("dec_pred_taken", decPredTaken, e[32]);
            chk32("dec_pred_target", decPredTarget, e[31:0]);
         end
      end
      if (imemRspValid && rsp_pending && !stray_rsp) begin
         if (!rsp_stale && !exRedirect)
            exp_q.push_back({instr_of(rsp_addr), rsp_addr, rsp_taken, rsp_tgt});
         rsp_pending = 1'b0;
         rsp_stale   = 1'b0;
      end
      if (rsp_pending && rsp_delay > 0) rsp_delay--;
      if (exRedirect) begin
         exp_q.delete();
         model_pc = {exRedirectPc[31:2], 2'b00};
         if (rsp_pending) rsp_stale = 1'b1;
      end else if (acc) begin
         rsp_pending = 1'b1;
         rsp_addr    = model_pc;
         rsp_taken   = fetchHit;
         rsp_tgt     = fetchHit ? {fetchTarget[31:2], 2'b00} : model_pc + 32'd4;
         model_pc    = rsp_tgt;
         rsp_delay   = mem_lat - 1;
      end
      cyc++;
      @(posedge clk);
      #1;
      exRedirect = 1'b0;
      stray_rsp  = 1'b0;
   endtask

   task automatic wait_accept(input logic [31:0] exp_addr, input string name);
      for (int i = 0; i < 20; i++) begin
         cycle();
         if (last_accept) begin
            chk32(name, last_addr, exp_addr);
            return;
         end
      end
      timeout(name);
   endtask

   task automatic wait_accept_any(input string name);
      for (int i = 0; i < 20; i++) begin
         cycle();
         if (last_accept) return;
      end
      timeout(name);
   endtask

   task automatic apply_reset();
      rst           = 1'b0;
      exRedirect    = 1'b0;
      model_pc      = RESET_PC;
      rsp_pending   = 1'b0;
      rsp_stale     = 1'b0;
      first_dec_cyc = -1;
      exp_q.delete();
      @(negedge clk);
      chk1("rst_imem_req", imemReq, 1'b0);
      chk1("rst_dec_valid", decValid, 1'b0);
      chk32("rst_fetch_pc", fetchPc, RESET_PC);
      chk32("rst_imem_addr", imemAddr, RESET_PC);
      chk1("rst_state", dbg_state, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   initial begin
      rst = 1'b0; fetchHit = 1'b0; fetchTarget = '0; imemReady = 1'b1;
      imemRspValid = 1'b0; imemRspData = '0; exRedirect = 1'b0; exRedirectPc = '0;
      decReady = 1'b1; mem_lat = 1; stray_rsp = 1'b0; cyc = 0; t0 = 0;
      last_acc_cyc = 0; rsp_delay = 0; rsp_addr = '0; rsp_tgt = '0; rsp_taken = 1'b0;

      vecs[0] = '{1'b0, 32'h0000_0000, 32'h0000_0000};
      vecs[1] = '{1'b0, 32'h0000_0000, 32'h0000_0004};
      vecs[2] = '{1'b1, 32'h0000_0100, 32'h0000_0008};
      vecs[3] = '{1'b0, 32'h0000_0000, 32'h0000_0100};
      vecs[4] = '{1'b1, 32'h0000_0013, 32'h0000_0104};
      vecs[5] = '{1'b0, 32'h0000_0000, 32'h0000_0010};
      vecs[6] = '{1'b0, 32'h0000_0000, 32'h0000_0014};

      @(posedge clk);
      #1;
      apply_reset();

      // Straight-line fetch and prediction redirects
      for (int i = 0; i < 7; i++) begin
         fetchHit    = vecs[i].hit;
         fetchTarget = vecs[i].target;
         wait_accept(vecs[i].exp_addr, "table_addr");
         if (i == 0) t0 = last_acc_cyc;
      end
      fetchHit = 1'b0;
      chk32("fetch_to_dec_latency", 32'(first_dec_cyc - t0), 32'd2);

      // Reset while a request is outstanding, then decode back-pressure
      mem_lat = 8;
      wait_accept_any("bp_pre_accept");
      cycle();
      apply_reset();
      stray_rsp = 1'b1;
      decReady  = 1'b0;
      mem_lat   = 1;
      for (int i = 0; i < 8; i++) cycle();
      chk1("bp_imem_req_held", imemReq, 1'b0);
      chk1("bp_dec_valid", decValid, 1'b1);
      chk32("bp_dec_pc_head", decPc, 32'h0000_0000);
      decReady = 1'b1;
      wait_accept(32'h0000_0008, "bp_resume_addr");

      // Redirect while waiting; the late response must be dropped
      for (int i = 0; i < 4; i++) cycle();
      mem_lat = 4;
      wait_accept_any("stale_pre_accept");
      exRedirect   = 1'b1;
      exRedirectPc = 32'h0000_0200;
      cycle();
      mem_lat = 1;
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk1("stale_dec_valid_low", decValid, 1'b0);
      end
      wait_accept(32'h0000_0200, "stale_refetch_addr");
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         if (decValid) found = 1'b1;
         else cycle();
      end
      if (!found) timeout("stale_dec_arrival");
      chk32("stale_dec_pc", decPc, 32'h0000_0200);
      chk32("stale_dec_instr", decInstr, instr_of(32'h0000_0200));

      // Redirect coinciding with a response and a pop, one entry buffered
      exRedirect   = 1'b1;
      exRedirectPc = 32'h0000_0300;
      cycle();
      decReady = 1'b0;
      found    = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (rsp_pending && rsp_delay == 0 && exp_q.size() == 1) found = 1'b1;
         else cycle();
      end
      if (!found) timeout("coin_setup");
      exRedirect   = 1'b1;
      exRedirectPc = 32'h0000_0203;
      decReady     = 1'b1;
      cycle();
      chk1("coin_dec_valid", decValid, 1'b0);
      wait_accept(32'h0000_0200, "coin_refetch_addr");

      // PC wrap at the top of the address space
      exRedirect   = 1'b1;
      exRedirectPc = 32'hFFFF_FFFC;
      cycle();
      wait_accept(32'hFFFF_FFFC, "wrap_addr_hi");
      wait_accept(32'h0000_0000, "wrap_addr_lo");

      // Random mix of stalls, predictions and redirects
      for (int i = 0; i < 300; i++) begin
         decReady    = ($urandom_range(0, 3) != 0);
         imemReady   = ($urandom_range(0, 3) != 0);
         mem_lat     = $urandom_range(1, 3);
         fetchHit    = ($urandom_range(0, 3) == 0);
         fetchTarget = $urandom();
         if ($urandom_range(0, 19) == 0) begin
            exRedirect   = 1'b1;
            exRedirectPc = $urandom();
         end
         cycle();
      end
      imemReady = 1'b1;
      decReady  = 1'b1;
      fetchHit  = 1'b0;
      for (int i = 0; i < 10; i++) cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
